// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the SPI slave receive path:
//   - MODE0..MODE3 : SPI mode encodings, {CPOL, CPHA}
//   - frame_st_t   : frame tracking state (disarmed / armed)
//   - sample_on_rise() : whether MOSI is sampled on a rising SCK edge
//   - idx_width() / cnt_width() : widths of frame index and word count
package spi_pkg;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,   // disarmed: sample edges ignored
      ST_ARMED = 1'b1    // CS fall seen, collecting bits
   } frame_st_t;

   // Modes 0 and 3 sample on SCK rising, modes 1 and 2 on falling.
   function automatic bit sample_on_rise(input int cpol, input int cpha);
      logic [1:0] mode;
      mode = {cpol[0], cpha[0]};
      return (mode == MODE0) || (mode == MODE3);
   endfunction

   // Index of a word inside a frame, 0..max_words-1 (at least one bit).
   function automatic int idx_width(input int max_words);
      return (max_words > 1) ? $clog2(max_words) : 1;
   endfunction

   // Completed-word count, 0..max_words.
   function automatic int cnt_width(input int max_words);
      return $clog2(max_words + 1);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Synchroniser for one asynchronous SPI pin plus edge detection.
//   Ports:
//     clk, rst : system clock, synchronous active-high reset
//     din      : asynchronous pin
//     level    : synchronised level, aligned with rise/fall
//     rise     : one-cycle pulse, level just went 0->1
//     fall     : one-cycle pulse, level just went 1->0
//   Pin-to-pulse latency is SYNC_STAGES+1 clk. Reset clears the chain to 0,
//   so a pin held low through reset release produces no fall pulse.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
)(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];
   // The delayed copy is the level that lines up with the registered pulses.
   assign level    = dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         dly_q  <= sync_out;
         rise   <= sync_out & ~dly_q;
         fall   <= ~sync_out & dly_q;
      end
   end

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   Oversampling SPI slave receiver. CS/SCK/MOSI are synchronised to clk;
//   each armed sample edge shifts one MOSI bit in, and every DATA_W bits a
//   word is offered on a valid/ready handshake together with its position
//   in the frame. CS deassertion of an armed frame pulses frame_done with
//   the word count and a stray-bit flag.
//   Ports:
//     clk, rst        : system clock, synchronous active-high reset
//     CS, SCK, MOSI   : SPI pins (CS active low), asynchronous to clk
//     rx_data/valid   : received word, held until accepted by rx_ready
//     rx_first        : word is the first of its frame
//     rx_index        : word position in frame, saturating at MAX_WORDS-1
//     frame_done      : one-cycle pulse at end of an armed frame
//     frame_words     : words completed in the last frame (saturating)
//     frame_partial   : last frame ended mid-word
//     overrun         : sticky, a completed word found rx_valid busy
//     busy            : CS low and frame armed
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter  int DATA_W      = 8,
   parameter  int CPOL        = 0,
   parameter  int CPHA        = 0,
   parameter  int MSB_FIRST   = 1,
   parameter  int SYNC_STAGES = 2,
   parameter  int MAX_WORDS   = 16,
   localparam int IDX_W       = idx_width(MAX_WORDS),
   localparam int CNT_W       = cnt_width(MAX_WORDS)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              CS,
   input  logic              SCK,
   input  logic              MOSI,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_first,
   output logic [IDX_W-1:0]  rx_index,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_words,
   output logic              frame_partial,
   output logic              overrun,
   output logic              busy
);

   localparam int BIT_W       = $clog2(DATA_W);
   localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   // ---------------------------------------------------------------
   // Pin synchronisers
   // ---------------------------------------------------------------
   logic cs_lvl, cs_rise, cs_fall;
   logic sck_lvl, sck_rise, sck_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
      .clk(clk), .rst(rst), .din(CS),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
      .clk(clk), .rst(rst), .din(SCK),
      .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
      .clk(clk), .rst(rst), .din(MOSI),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
   );

   // Only the MOSI level and the SCK edges are needed.
   logic unused_sync;
   assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};

   // ---------------------------------------------------------------
   // Frame state
   // ---------------------------------------------------------------
   frame_st_t state_q, state_d;

   logic [DATA_W-1:0] sh_q;
   logic [BIT_W-1:0]  bit_q;
   logic [CNT_W-1:0]  wcnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cs_fall) state_d = ST_ARMED;
         ST_ARMED: if (cs_rise) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------
   logic              sample, word_done, load, accept, frame_end;
   logic [DATA_W-1:0] sh_in;
   logic [BIT_W-1:0]  bit_after;
   logic [CNT_W-1:0]  wcnt_after;
   logic [IDX_W-1:0]  idx_sat;

   always_comb begin
      sample    = (state_q == ST_ARMED) && !cs_lvl &&
                  (SAMPLE_RISE ? sck_rise : sck_fall);
      sh_in     = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], mosi_lvl}
                                   : {mosi_lvl, sh_q[DATA_W-1:1]};
      word_done = sample && (bit_q == BIT_W'(DATA_W-1));

      bit_after = bit_q;
      if (sample) bit_after = word_done ? '0 : bit_q + 1'b1;

      wcnt_after = wcnt_q;
      if (word_done && (wcnt_q != CNT_W'(MAX_WORDS))) wcnt_after = wcnt_q + 1'b1;

      accept = rx_valid && rx_ready;
      // A word may only replace rx_data if the slot is free or emptying now.
      load   = word_done && (!rx_valid || rx_ready);

      // The sample is applied first, so a word completing on the same cycle
      // as CS rising is part of frame_words.
      frame_end = (state_q == ST_ARMED) && cs_rise;

      idx_sat = (wcnt_q >= CNT_W'(MAX_WORDS-1)) ? IDX_W'(MAX_WORDS-1)
                                                 : wcnt_q[IDX_W-1:0];
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q          <= '0;
         bit_q         <= '0;
         wcnt_q        <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_first      <= 1'b0;
         rx_index      <= '0;
         frame_done    <= 1'b0;
         frame_words   <= '0;
         frame_partial <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         frame_done <= frame_end;

         if (sample) sh_q <= sh_in;

         if (cs_fall) begin
            bit_q   <= '0;
            wcnt_q  <= '0;
            overrun <= 1'b0;
         end else begin
            wcnt_q <= wcnt_after;
            if (word_done && !load) overrun <= 1'b1;
            if (frame_end) begin
               // Any stray bits are discarded here.
               bit_q         <= '0;
               frame_words   <= wcnt_after;
               frame_partial <= (bit_after != '0);
            end else begin
               bit_q <= bit_after;
            end
         end

         if (load) begin
            rx_data  <= sh_in;
            rx_index <= idx_sat;
            rx_first <= (wcnt_q == '0);
            rx_valid <= 1'b1;
         end else if (accept) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = !cs_lvl && (state_q == ST_ARMED);

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx
//   Directed bench: DUT a is mode 0 / 8-bit / MSB first, DUT b is
//   mode 3 / 16-bit / LSB first. Accepted words and frame_done pulses are
//   recorded by negedge monitors and checked after each scenario.
module tb_spi_slave_rx;

   localparam int HALF  = 10;   // SCK half period in clk cycles
   localparam int SETUP = 5;    // CS to first/last SCK activity, clk cycles
   localparam int NSYNC = 2;

   logic clk = 1'b0;
   logic rst;
   always #1 clk = ~clk;

   // DUT a
   logic       a_cs, a_sck, a_mosi, a_ready;
   logic [7:0] a_data;
   logic       a_valid, a_first, a_done, a_fp, a_ovr, a_busy;
   logic [3:0] a_idx;
   logic [4:0] a_fw;

   // DUT b
   logic        b_cs, b_sck, b_mosi, b_ready;
   logic [15:0] b_data;
   logic        b_valid, b_first, b_done, b_fp, b_ovr, b_busy;
   logic [3:0]  b_idx;
   logic [4:0]  b_fw;

   spi_slave_rx u_a (
      .clk(clk), .rst(rst), .CS(a_cs), .SCK(a_sck), .MOSI(a_mosi),
      .rx_data(a_data), .rx_valid(a_valid), .rx_ready(a_ready),
      .rx_first(a_first), .rx_index(a_idx), .frame_done(a_done),
      .frame_words(a_fw), .frame_partial(a_fp), .overrun(a_ovr), .busy(a_busy)
   );

   spi_slave_rx #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0),
                  .SYNC_STAGES(NSYNC), .MAX_WORDS(16)) u_b (
      .clk(clk), .rst(rst), .CS(b_cs), .SCK(b_sck), .MOSI(b_mosi),
      .rx_data(b_data), .rx_valid(b_valid), .rx_ready(b_ready),
      .rx_first(b_first), .rx_index(b_idx), .frame_done(b_done),
      .frame_words(b_fw), .frame_partial(b_fp), .overrun(b_ovr), .busy(b_busy)
   );

   // Monitors
   logic [7:0] aq_data[$];
   logic [3:0] aq_idx[$];
   logic       aq_first[$];
   int         a_done_cnt = 0;
   int         b_done_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (a_valid && a_ready) begin
            aq_data.push_back(a_data);
            aq_idx.push_back(a_idx);
            aq_first.push_back(a_first);
         end
         if (a_done) a_done_cnt++;
         if (b_done) b_done_cnt++;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode 0, MSB first: first n bits of b.
   task automatic a_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         a_mosi = b[i];
         cyc(HALF);
         a_sck = 1'b1;
         cyc(HALF);
         a_sck = 1'b0;
      end
   endtask

   task automatic a_cs_low;
      a_cs = 1'b0;
      cyc(SETUP);
   endtask

   task automatic a_cs_high;
      cyc(SETUP);
      a_cs = 1'b1;
      cyc(20);
   endtask

   int base, dbase;
   logic [15:0] w16;

   initial begin
      rst = 1'b1;
      a_cs = 1'b1; a_sck = 1'b0; a_mosi = 1'b0; a_ready = 1'b1;
      b_cs = 1'b1; b_sck = 1'b1; b_mosi = 1'b0; b_ready = 1'b1;
      cyc(4);

      // Reset state
      chk("rst_valid",   a_valid, 0);
      chk("rst_data",    a_data,  0);
      chk("rst_words",   a_fw,    0);
      chk("rst_partial", a_fp,    0);
      chk("rst_overrun", a_ovr,   0);
      chk("rst_busy",    a_busy,  0);
      chk("rst_done",    a_done,  0);
      rst = 1'b0;
      cyc(10);

      // 1: single byte 0x02
      base = aq_data.size(); dbase = a_done_cnt;
      a_cs_low();
      chk("t1_busy", a_busy, 1);
      a_bits(8'h02, 8);
      a_cs_high();
      chk("t1_nwords", aq_data.size() - base, 1);
      chk("t1_data",   aq_data[base],  8'h02);
      chk("t1_first",  aq_first[base], 1);
      chk("t1_idx",    aq_idx[base],   0);
      chk("t1_ndone",  a_done_cnt - dbase, 1);
      chk("t1_fw",     a_fw, 1);
      chk("t1_fp",     a_fp, 0);
      chk("t1_ovr",    a_ovr, 0);
      chk("t1_busy_end", a_busy, 0);

      // 2: three-byte frame
      base = aq_data.size();
      a_cs_low();
      a_bits(8'hA5, 8); a_bits(8'h3C, 8); a_bits(8'hFF, 8);
      a_cs_high();
      chk("t2_nwords", aq_data.size() - base, 3);
      chk("t2_d0", aq_data[base],   8'hA5);
      chk("t2_d1", aq_data[base+1], 8'h3C);
      chk("t2_d2", aq_data[base+2], 8'hFF);
      chk("t2_i0", aq_idx[base],   0);
      chk("t2_i1", aq_idx[base+1], 1);
      chk("t2_i2", aq_idx[base+2], 2);
      chk("t2_f0", aq_first[base],   1);
      chk("t2_f1", aq_first[base+1], 0);
      chk("t2_f2", aq_first[base+2], 0);
      chk("t2_fw", a_fw, 3);

      // 3: overrun with rx_ready low
      base = aq_data.size();
      a_ready = 1'b0;
      a_cs_low();
      a_bits(8'h11, 8); a_bits(8'h22, 8);
      a_cs_high();
      chk("t3_valid_held", a_valid, 1);
      chk("t3_data_held",  a_data,  8'h11);
      chk("t3_ovr",        a_ovr,   1);
      chk("t3_fw",         a_fw,    2);
      chk("t3_no_accept",  aq_data.size() - base, 0);
      a_ready = 1'b1;
      cyc(4);
      chk("t3_nwords", aq_data.size() - base, 1);
      chk("t3_acc",    aq_data[base], 8'h11);
      chk("t3_valid_low", a_valid, 0);
      a_cs_low();
      chk("t3_ovr_clr", a_ovr, 0);
      a_cs_high();

      // 4: partial word, 5 bits of 0xF0
      base = aq_data.size(); dbase = a_done_cnt;
      a_cs_low();
      a_bits(8'hF0, 5);
      a_cs_high();
      chk("t4_nwords", aq_data.size() - base, 0);
      chk("t4_ndone",  a_done_cnt - dbase, 1);
      chk("t4_fw",     a_fw, 0);
      chk("t4_fp",     a_fp, 1);

      // 5: mode 3, 16-bit, LSB first, latency from final pin edge
      w16 = 16'h1234;
      dbase = b_done_cnt;
      b_cs = 1'b0;
      cyc(SETUP);
      for (int i = 0; i < 16; i++) begin
         b_sck = 1'b0;
         b_mosi = w16[i];
         cyc(HALF);
         b_sck = 1'b1;
         if (i == 15) begin
            cyc(NSYNC + 1);
            chk("t5_valid_early", b_valid, 0);
            cyc(1);
            chk("t5_valid_ontime", b_valid, 1);
            chk("t5_data",  b_data,  16'h1234);
            chk("t5_first", b_first, 1);
            cyc(HALF - NSYNC - 2);
         end else begin
            cyc(HALF);
         end
      end
      cyc(SETUP);
      b_cs = 1'b1;
      cyc(20);
      chk("t5_ndone", b_done_cnt - dbase, 1);
      chk("t5_fw",    b_fw, 1);
      chk("t5_fp",    b_fp, 0);

      // 6: reset mid-frame, CS still low afterwards
      base = aq_data.size(); dbase = a_done_cnt;
      a_cs_low();
      a_bits(8'hFF, 4);
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      a_bits(8'hAA, 8); a_bits(8'h55, 4);
      chk("t6_busy", a_busy, 0);
      a_cs_high();
      chk("t6_nwords", aq_data.size() - base, 0);
      chk("t6_ndone",  a_done_cnt - dbase, 0);
      a_cs_low();
      a_bits(8'h5A, 8);
      a_cs_high();
      chk("t6_nwords2", aq_data.size() - base, 1);
      chk("t6_data",    aq_data[base], 8'h5A);
      chk("t6_first",   aq_first[base], 1);
      chk("t6_ndone2",  a_done_cnt - dbase, 1);
      chk("t6_fw",      a_fw, 1);
      chk("t6_fp",      a_fp, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
